// File: rtl/auth_arb_pkg.sv
// Shared types and helpers for the authentication request arbiter.
// Holds the FSM state encoding, slot codes, channel ids and slot selection.
package auth_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    REQ,
    WAIT_RESP,
    DELIVER
  } arb_state_e;

  localparam logic [1:0]  SLOT_EMPTY = 2'b00;
  localparam int unsigned NUM_SLOTS  = 4;

  localparam logic CH_PD    = 1'b0;
  localparam logic CH_DEBUG = 1'b1;

  // Index of the lowest slot whose 2-bit code is not empty; 0 when all are empty.
  function automatic logic [1:0] lowest_slot(input logic [7:0] pend);
    logic [1:0] sel;
    logic       found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!found && pend[2*i +: 2] != SLOT_EMPTY) begin
        sel   = 2'(i);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/auth_rr_arbiter.sv
// Two-way round-robin arbiter between the PD and DEBUG channels.
// The registered last-grant pointer resets to DEBUG so PD wins the first tie.
module auth_rr_arbiter
  import auth_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] eligible,
  input  logic       grant_en,
  output logic [1:0] grant,
  output logic       last_q
);

  logic last_d;

  always_comb begin
    grant = '0;
    if (grant_en) begin
      if (&eligible) begin
        grant = (last_q == CH_PD) ? 2'b10 : 2'b01;
      end else begin
        grant = eligible;
      end
    end
    last_d = last_q;
    if (|grant) begin
      last_d = grant[CH_DEBUG];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= CH_DEBUG;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/auth_request_arbiter.sv
// Arbitrates PD/DEBUG authentication requests onto a single auth driver.
// Optional WAIT_RESP timeout is enabled by defining AUTH_TX_TIMEOUT_EN.
`ifndef MSG_LEN
`define MSG_LEN 32
`endif

module auth_request_arbiter
  import auth_arb_pkg::*;
#(
  parameter int unsigned MSG_W       = `MSG_LEN,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [MSG_W-1:0] pd_msg_in,
  input  logic [MSG_W-1:0] debug_msg_in,
  input  logic             PD_msg_ready,
  input  logic             DEBUG_msg_ready,
  output logic             PD_ready,
  output logic             DEBUG_ready,
  input  logic [7:0]       pending_auth_request_PD,
  input  logic [7:0]       pending_auth_request_DEBUG,
  output logic             pending_auth_request_PD_erase,
  output logic             pending_auth_request_DEBUG_erase,
  output logic [1:0]       erase_slot,
  output logic [MSG_W-1:0] auth_msg_in,
  output logic             resp_req_in,
  input  logic             resp_req_out,
  input  logic [MSG_W-1:0] auth_msg_out,
  input  logic             auth_msg_ready,
  output logic             Ack_in_driver,
  output logic [MSG_W-1:0] pd_resp_out,
  output logic [MSG_W-1:0] debug_resp_out,
  output logic             pd_resp_valid,
  output logic             debug_resp_valid,
  input  logic             pd_resp_ack,
  input  logic             debug_resp_ack,
  output logic             busy,
  output logic             timeout_err
);

  if (TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("TIMEOUT_CYC must be at least 1");
  end

  arb_state_e       state_q, state_d;
  logic             gnt_ch_q, gnt_ch_d;
  logic [1:0]       slot_q, slot_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [MSG_W-1:0] resp_q, resp_d;
  logic             pd_ready_q, pd_ready_d;
  logic             dbg_ready_q, dbg_ready_d;
  logic             ack_q, ack_d;
  logic             pd_erase_q, pd_erase_d;
  logic             dbg_erase_q, dbg_erase_d;
  logic [1:0]       erase_slot_q, erase_slot_d;

  logic [1:0] eligible;
  logic [1:0] grant;
  logic       last_grant;
  logic       chan_ack;

`ifdef AUTH_TX_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  assign eligible[CH_PD]    = PD_msg_ready    && (pending_auth_request_PD    != '0);
  assign eligible[CH_DEBUG] = DEBUG_msg_ready && (pending_auth_request_DEBUG != '0);

  auth_rr_arbiter u_rr (
    .clk      (clk),
    .reset    (reset),
    .eligible (eligible),
    .grant_en (state_q == IDLE),
    .grant    (grant),
    .last_q   (last_grant)
  );

  assign chan_ack = (gnt_ch_q == CH_DEBUG) ? debug_resp_ack : pd_resp_ack;

  always_comb begin
    state_d      = state_q;
    gnt_ch_d     = gnt_ch_q;
    slot_d       = slot_q;
    msg_d        = msg_q;
    resp_d       = resp_q;
    pd_ready_d   = 1'b0;
    dbg_ready_d  = 1'b0;
    ack_d        = 1'b0;
    pd_erase_d   = 1'b0;
    dbg_erase_d  = 1'b0;
    erase_slot_d = '0;
`ifdef AUTH_TX_TIMEOUT_EN
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|grant) begin
          state_d     = GRANT;
          gnt_ch_d    = grant[CH_DEBUG];
          msg_d       = grant[CH_DEBUG] ? debug_msg_in : pd_msg_in;
          slot_d      = lowest_slot(grant[CH_DEBUG] ? pending_auth_request_DEBUG
                                                    : pending_auth_request_PD);
          pd_ready_d  = grant[CH_PD];
          dbg_ready_d = grant[CH_DEBUG];
        end
      end
      GRANT: state_d = REQ;
      REQ: begin
        if (resp_req_out) begin
          state_d = WAIT_RESP;
`ifdef AUTH_TX_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT_RESP: begin
        if (auth_msg_ready) begin
          resp_d  = auth_msg_out;
          ack_d   = 1'b1;
          state_d = DELIVER;
        end
`ifdef AUTH_TX_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DELIVER: begin
        if (chan_ack) begin
          pd_erase_d   = (gnt_ch_q == CH_PD);
          dbg_erase_d  = (gnt_ch_q == CH_DEBUG);
          erase_slot_d = slot_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      gnt_ch_q     <= CH_PD;
      slot_q       <= '0;
      msg_q        <= '0;
      resp_q       <= '0;
      pd_ready_q   <= 1'b0;
      dbg_ready_q  <= 1'b0;
      ack_q        <= 1'b0;
      pd_erase_q   <= 1'b0;
      dbg_erase_q  <= 1'b0;
      erase_slot_q <= '0;
`ifdef AUTH_TX_TIMEOUT_EN
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_ch_q     <= gnt_ch_d;
      slot_q       <= slot_d;
      msg_q        <= msg_d;
      resp_q       <= resp_d;
      pd_ready_q   <= pd_ready_d;
      dbg_ready_q  <= dbg_ready_d;
      ack_q        <= ack_d;
      pd_erase_q   <= pd_erase_d;
      dbg_erase_q  <= dbg_erase_d;
      erase_slot_q <= erase_slot_d;
`ifdef AUTH_TX_TIMEOUT_EN
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign PD_ready                         = pd_ready_q;
  assign DEBUG_ready                      = dbg_ready_q;
  assign Ack_in_driver                    = ack_q;
  assign pending_auth_request_PD_erase    = pd_erase_q;
  assign pending_auth_request_DEBUG_erase = dbg_erase_q;
  assign erase_slot                       = erase_slot_q;
  assign auth_msg_in                      = msg_q;
  assign resp_req_in                      = (state_q == REQ);
  assign busy                             = (state_q != IDLE);
  assign pd_resp_valid                    = (state_q == DELIVER) && (gnt_ch_q == CH_PD);
  assign debug_resp_valid                 = (state_q == DELIVER) && (gnt_ch_q == CH_DEBUG);
  assign pd_resp_out                      = (gnt_ch_q == CH_PD)    ? resp_q : '0;
  assign debug_resp_out                   = (gnt_ch_q == CH_DEBUG) ? resp_q : '0;
`ifdef AUTH_TX_TIMEOUT_EN
  assign timeout_err                      = timeout_q;
`else
  assign timeout_err                      = 1'b0;
`endif

endmodule

// File: tb/tb_auth_request_arbiter.sv
// Directed self-checking bench for auth_request_arbiter.
// Covers the timeout path only when AUTH_TX_TIMEOUT_EN is defined.
module tb_auth_request_arbiter;

  localparam int unsigned MSG_W = 32;
  localparam int unsigned TO    = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [MSG_W-1:0] pd_msg_in, debug_msg_in;
  logic             PD_msg_ready, DEBUG_msg_ready;
  logic             PD_ready, DEBUG_ready;
  logic [7:0]       pending_auth_request_PD, pending_auth_request_DEBUG;
  logic             pending_auth_request_PD_erase, pending_auth_request_DEBUG_erase;
  logic [1:0]       erase_slot;
  logic [MSG_W-1:0] auth_msg_in;
  logic             resp_req_in, resp_req_out;
  logic [MSG_W-1:0] auth_msg_out;
  logic             auth_msg_ready, Ack_in_driver;
  logic [MSG_W-1:0] pd_resp_out, debug_resp_out;
  logic             pd_resp_valid, debug_resp_valid;
  logic             pd_resp_ack, debug_resp_ack;
  logic             busy, timeout_err;

  int tests = 0;
  int fails = 0;

  auth_request_arbiter #(.MSG_W(MSG_W), .TIMEOUT_CYC(TO)) dut (
    .clk                              (clk),
    .reset                            (reset),
    .pd_msg_in                        (pd_msg_in),
    .debug_msg_in                     (debug_msg_in),
    .PD_msg_ready                     (PD_msg_ready),
    .DEBUG_msg_ready                  (DEBUG_msg_ready),
    .PD_ready                         (PD_ready),
    .DEBUG_ready                      (DEBUG_ready),
    .pending_auth_request_PD          (pending_auth_request_PD),
    .pending_auth_request_DEBUG       (pending_auth_request_DEBUG),
    .pending_auth_request_PD_erase    (pending_auth_request_PD_erase),
    .pending_auth_request_DEBUG_erase (pending_auth_request_DEBUG_erase),
    .erase_slot                       (erase_slot),
    .auth_msg_in                      (auth_msg_in),
    .resp_req_in                      (resp_req_in),
    .resp_req_out                     (resp_req_out),
    .auth_msg_out                     (auth_msg_out),
    .auth_msg_ready                   (auth_msg_ready),
    .Ack_in_driver                    (Ack_in_driver),
    .pd_resp_out                      (pd_resp_out),
    .debug_resp_out                   (debug_resp_out),
    .pd_resp_valid                    (pd_resp_valid),
    .debug_resp_valid                 (debug_resp_valid),
    .pd_resp_ack                      (pd_resp_ack),
    .debug_resp_ack                   (debug_resp_ack),
    .busy                             (busy),
    .timeout_err                      (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled and inputs changed 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Complete one transaction for channel ch (0=PD, 1=DEBUG); caller sets eligibility.
  task automatic serve(input string tag, input logic ch, input logic [1:0] slot,
                       input logic [MSG_W-1:0] msg, input logic [MSG_W-1:0] resp);
    tick();
    check({tag, "_pd_ready"}, PD_ready, !ch);
    check({tag, "_dbg_ready"}, DEBUG_ready, ch);
    check({tag, "_req_early"}, resp_req_in, 1'b0);
    tick();
    check({tag, "_req"}, resp_req_in, 1'b1);
    check({tag, "_msg"}, auth_msg_in, msg);
    resp_req_out = 1'b1;
    tick();
    resp_req_out = 1'b0;
    check({tag, "_req_drop"}, resp_req_in, 1'b0);
    auth_msg_ready = 1'b1;
    auth_msg_out   = resp;
    tick();
    auth_msg_ready = 1'b0;
    check({tag, "_ack"}, Ack_in_driver, 1'b1);
    check({tag, "_pd_valid"}, pd_resp_valid, !ch);
    check({tag, "_dbg_valid"}, debug_resp_valid, ch);
    check({tag, "_resp"}, ch ? debug_resp_out : pd_resp_out, resp);
    if (ch) debug_resp_ack = 1'b1; else pd_resp_ack = 1'b1;
    tick();
    debug_resp_ack = 1'b0;
    pd_resp_ack    = 1'b0;
    check({tag, "_pd_erase"}, pending_auth_request_PD_erase, !ch);
    check({tag, "_dbg_erase"}, pending_auth_request_DEBUG_erase, ch);
    check({tag, "_slot"}, erase_slot, slot);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_valid_drop"}, ch ? debug_resp_valid : pd_resp_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    pd_msg_in = '0; debug_msg_in = '0;
    PD_msg_ready = 1'b0; DEBUG_msg_ready = 1'b0;
    pending_auth_request_PD = '0; pending_auth_request_DEBUG = '0;
    resp_req_out = 1'b0; auth_msg_out = '0; auth_msg_ready = 1'b0;
    pd_resp_ack = 1'b0; debug_resp_ack = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_req", resp_req_in, 1'b0);
    check("rst_ack", Ack_in_driver, 1'b0);
    check("rst_erase", {pending_auth_request_PD_erase, pending_auth_request_DEBUG_erase}, 2'b00);
    check("rst_msg", auth_msg_in, '0);
    check("rst_valid", {pd_resp_valid, debug_resp_valid}, 2'b00);
    check("rst_to", timeout_err, 1'b0);
    reset = 1'b1;

    // auth_msg_ready while idle is ignored
    auth_msg_ready = 1'b1;
    tick();
    auth_msg_ready = 1'b0;
    check("idle_ready_ack", Ack_in_driver, 1'b0);
    check("idle_ready_busy", busy, 1'b0);

    // Test 1: single PD transaction, with auth_msg_ready pulsed during REQ
    PD_msg_ready = 1'b1; pd_msg_in = 32'hA5A5_0001; pending_auth_request_PD = 8'h0B;
    tick();
    PD_msg_ready = 1'b0;
    check("t1_pd_ready", PD_ready, 1'b1);
    check("t1_busy", busy, 1'b1);
    check("t1_req_early", resp_req_in, 1'b0);
    tick();
    check("t1_req", resp_req_in, 1'b1);
    check("t1_msg", auth_msg_in, 32'hA5A5_0001);
    check("t1_pd_ready_drop", PD_ready, 1'b0);
    auth_msg_ready = 1'b1; auth_msg_out = 32'hDEAD_0000;
    tick();
    auth_msg_ready = 1'b0;
    check("t4_req_ack", Ack_in_driver, 1'b0);
    check("t4_req_hold", resp_req_in, 1'b1);
    resp_req_out = 1'b1;
    tick();
    resp_req_out = 1'b0;
    check("t1_req_drop", resp_req_in, 1'b0);
    check("t1_wait_ack", Ack_in_driver, 1'b0);
    auth_msg_ready = 1'b1; auth_msg_out = 32'h1234_5678;
    tick();
    auth_msg_ready = 1'b0;
    check("t1_ack", Ack_in_driver, 1'b1);
    check("t1_pd_valid", pd_resp_valid, 1'b1);
    check("t1_dbg_valid", debug_resp_valid, 1'b0);
    check("t1_resp", pd_resp_out, 32'h1234_5678);
    tick();
    check("t1_ack_once", Ack_in_driver, 1'b0);
    check("t1_valid_hold", pd_resp_valid, 1'b1);
    pd_resp_ack = 1'b1;
    tick();
    pd_resp_ack = 1'b0;
    check("t1_erase", pending_auth_request_PD_erase, 1'b1);
    check("t1_slot", erase_slot, 2'd0);
    check("t1_valid_drop", pd_resp_valid, 1'b0);
    check("t1_idle", busy, 1'b0);
    tick();
    check("t1_erase_once", pending_auth_request_PD_erase, 1'b0);

    // Test 2: both eligible from reset, alternating grants
    reset = 1'b0; tick(); reset = 1'b1;
    PD_msg_ready = 1'b1; DEBUG_msg_ready = 1'b1;
    pd_msg_in = 32'h0000_00AA; debug_msg_in = 32'h0000_00BB;
    pending_auth_request_PD = 8'h08; pending_auth_request_DEBUG = 8'h08;
    serve("t2a", 1'b0, 2'd1, 32'h0000_00AA, 32'h1111_0001);
    serve("t2b", 1'b1, 2'd1, 32'h0000_00BB, 32'h2222_0002);
    serve("t2c", 1'b0, 2'd1, 32'h0000_00AA, 32'h1111_0003);
    serve("t2d", 1'b1, 2'd1, 32'h0000_00BB, 32'h2222_0004);
    PD_msg_ready = 1'b0;
    pending_auth_request_DEBUG = 8'h00;

    // Test 3: DEBUG ready with an empty pending byte is never granted
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_busy", busy, 1'b0);
      check("t3_dbg_ready", DEBUG_ready, 1'b0);
    end
    DEBUG_msg_ready = 1'b0;

    // Test 5: reset during WAIT_RESP, then PD re-granted
    PD_msg_ready = 1'b1; pd_msg_in = 32'h0000_0055; pending_auth_request_PD = 8'h30;
    tick(); tick();
    resp_req_out = 1'b1;
    tick();
    resp_req_out = 1'b0;
    check("t5_wait_busy", busy, 1'b1);
    reset = 1'b0;
    tick();
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_erase", pending_auth_request_PD_erase, 1'b0);
    check("t5_rst_ready", PD_ready, 1'b0);
    check("t5_rst_msg", auth_msg_in, '0);
    reset = 1'b1;
    serve("t5", 1'b0, 2'd2, 32'h0000_0055, 32'h5555_AAAA);
    PD_msg_ready = 1'b0;

    // Test 6: no response from the driver in WAIT_RESP
    PD_msg_ready = 1'b1; pd_msg_in = 32'h0000_0066; pending_auth_request_PD = 8'h01;
    tick();
    PD_msg_ready = 1'b0;
    tick();
    resp_req_out = 1'b1;
    tick();
    resp_req_out = 1'b0;
`ifdef AUTH_TX_TIMEOUT_EN
    for (int i = 1; i < int'(TO); i++) begin
      tick();
      check("t6_to_early", timeout_err, 1'b0);
    end
    tick();
    check("t6_to", timeout_err, 1'b1);
    check("t6_to_idle", busy, 1'b0);
    check("t6_to_erase", pending_auth_request_PD_erase, 1'b0);
    check("t6_to_valid", pd_resp_valid, 1'b0);
    tick();
    check("t6_to_once", timeout_err, 1'b0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      check("t6_no_to", timeout_err, 1'b0);
    end
    check("t6_still_busy", busy, 1'b1);
    check("t6_no_valid", pd_resp_valid, 1'b0);
    check("t6_no_req", resp_req_in, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
